// File: rtl/des_perm_pipe.sv
// des_perm_pipe
//   Programmable bit permutation with a valid/ready pipeline. A table of
//   WIDTH entries selects, for every output bit k, which input bit feeds it
//   (DES numbering: bit 0 is the MSB). The permutation is applied when a
//   word is accepted and the result then flows through STAGES registers.
//   On reset the table holds the DES P permutation when WIDTH is 32 and the
//   identity mapping otherwise.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   cfg_we     : table write strobe
//   cfg_idx    : output bit position being written
//   cfg_src    : input bit that position should copy
//   cfg_err    : one-cycle pulse after a rejected (out-of-range) write
//   in_valid   : in_data holds a word
//   in_ready   : the block takes in_data this cycle
//   in_data    : word to permute, [0:WIDTH-1], bit 0 = MSB
//   out_valid  : out_data holds a permuted word
//   out_ready  : consumer takes out_data this cycle
//   out_data   : permuted word, straight from the last stage register
module des_perm_pipe #(
   parameter int WIDTH  = 32,
   parameter int IDX_W  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [IDX_W-1:0] cfg_src,
   output logic             cfg_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:WIDTH-1] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:WIDTH-1] out_data
);

   // DES P permutation: entry k is the input bit that drives output bit k.
   localparam logic [4:0] DES_P [0:31] = '{
      5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
      5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
      5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
      5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
   };

   // Reset value of table entry k.
   function automatic logic [IDX_W-1:0] reset_entry(input logic [6:0] k);
      logic [IDX_W-1:0] e;
      if (WIDTH == 32) begin
         e = IDX_W'(DES_P[k[4:0]]);
      end else begin
         e = IDX_W'(k);
      end
      return e;
   endfunction

   logic [IDX_W-1:0] perm_tab   [0:WIDTH-1];
   logic [0:WIDTH-1] stage_data [1:STAGES];
   logic [1:STAGES]  stage_vld;
   logic [1:STAGES]  stage_adv;
   logic [0:WIDTH-1] permuted;
   logic             cfg_ok;
   logic             accept;

   // A write is only honoured when both fields name an existing bit.
   always_comb begin
      cfg_ok = 1'b0;
      if ((32'(cfg_idx) < 32'(WIDTH)) && (32'(cfg_src) < 32'(WIDTH))) begin
         cfg_ok = 1'b1;
      end else begin
         cfg_ok = 1'b0;
      end
   end

   // Gather network: output bit k copies the input bit named by entry k.
   always_comb begin
      permuted = '0;
      for (int k = 0; k < WIDTH; k++) begin
         permuted[k] = in_data[perm_tab[k]];
      end
   end

   // Advance flags: a full stage moves on if some later stage has a hole,
   // or if every later stage is full and the consumer drains the last one.
   // Scanning from the tail keeps this free of self-referencing logic.
   always_comb begin
      logic bubble;
      bubble    = 1'b0;
      stage_adv = '0;
      for (int s = STAGES; s >= 1; s--) begin
         stage_adv[s] = stage_vld[s] & (out_ready | bubble);
         bubble       = bubble | ~stage_vld[s];
      end
   end

   // Input handshake; held low throughout reset.
   always_comb begin
      in_ready = 1'b0;
      if (rst) begin
         in_ready = 1'b0;
      end else begin
         in_ready = ~stage_vld[1] | stage_adv[1];
      end
   end

   assign accept = in_valid & in_ready;

   // Table storage. A write in the same cycle as an acceptance lands at the
   // edge, so that word was already permuted with the old entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < WIDTH; k++) begin
            perm_tab[k] <= reset_entry(7'(k));
         end
      end else if (cfg_we && cfg_ok) begin
         perm_tab[cfg_idx] <= cfg_src;
      end
   end

   // Rejected-write flag, visible for exactly the cycle after the write.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we & ~cfg_ok;
      end
   end

   // Stage 1: loads the permuted word on acceptance, empties when it moves on.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_vld[1]  <= 1'b0;
         stage_data[1] <= '0;
      end else if (accept) begin
         stage_vld[1]  <= 1'b1;
         stage_data[1] <= permuted;
      end else if (stage_adv[1]) begin
         stage_vld[1]  <= 1'b0;
      end
   end

   for (genvar s = 2; s <= STAGES; s++) begin : g_stage
      // Stage s: takes the word from stage s-1, empties when it moves on.
      always_ff @(posedge clk) begin
         if (rst) begin
            stage_vld[s]  <= 1'b0;
            stage_data[s] <= '0;
         end else if (stage_adv[s-1]) begin
            stage_vld[s]  <= 1'b1;
            stage_data[s] <= stage_data[s-1];
         end else if (stage_adv[s]) begin
            stage_vld[s]  <= 1'b0;
         end
      end
   end

   assign out_valid = stage_vld[STAGES];
   assign out_data  = stage_data[STAGES];

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb_des_perm_pipe
//   Main instance: WIDTH=32, STAGES=2, checked every cycle against a
//   behavioural model (table array + expected-word queue) plus literal
//   expectations. A second instance (WIDTH=24, STAGES=1) covers rejected
//   table writes, which a 5-bit index cannot express at WIDTH=32, and the
//   identity reset table.
`timescale 1ns/1ps
module tb_des_perm_pipe;
   localparam int W  = 32;
   localparam int ST = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [4:0]  cfg_idx;
   logic [4:0]  cfg_src;
   logic        cfg_err;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   logic        s_rst;
   logic        s_cfg_we;
   logic [4:0]  s_cfg_idx;
   logic [4:0]  s_cfg_src;
   logic        s_cfg_err;
   logic        s_in_valid;
   logic        s_in_ready;
   logic [23:0] s_in_data;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [23:0] s_out_data;

   des_perm_pipe #(.WIDTH(32), .IDX_W(5), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src(cfg_src),
      .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   des_perm_pipe #(.WIDTH(24), .IDX_W(5), .STAGES(1)) u_small (
      .clk(clk), .rst(s_rst), .cfg_we(s_cfg_we), .cfg_idx(s_cfg_idx), .cfg_src(s_cfg_src),
      .cfg_err(s_cfg_err), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int p_tab [32] = '{15, 6, 19, 20, 28, 11, 27, 16, 0, 14, 22, 25, 4, 17, 30, 9,
                      1, 7, 23, 13, 31, 26, 2, 8, 18, 12, 29, 5, 21, 10, 3, 24};
   int model_tab [32];
   logic [31:0] exp_q [$];
   int          acc_q [$];
   logic [31:0] got_q [$];

   // DES numbering: bit j of a word is value bit (31 - j).
   function automatic logic [31:0] p_model(input logic [31:0] w, input int tab [32]);
      logic [31:0] r;
      r = 32'd0;
      for (int k = 0; k < 32; k++) begin
         if (((w >> (31 - tab[k])) & 32'd1) != 32'd0) begin
            r = r | (32'h8000_0000 >> k);
         end
      end
      return r;
   endfunction

   int          cyc        = 0;
   int          last_stall = -1;
   logic        prev_rst   = 1'b1;
   logic        prev_stall = 1'b0;
   logic        err_exp    = 1'b0;
   logic [31:0] prev_data  = 32'd0;

   // Compare process: sampled on the falling edge, describes the coming rising edge.
   always @(negedge clk) begin : cmp
      int a;
      cyc++;
      if (prev_rst) begin
         check("post_rst_out_valid", out_valid, 1'b0);
         check("post_rst_cfg_err", cfg_err, 1'b0);
      end else begin
         check("cfg_err", cfg_err, err_exp);
      end
      if (prev_stall && !prev_rst) begin
         check("stall_valid_held", out_valid, 1'b1);
         check("stall_data_held", out_data, prev_data);
      end
      if (rst) begin
         check("rst_in_ready", in_ready, 1'b0);
      end else if (prev_rst || out_ready) begin
         check("in_ready", in_ready, 1'b1);
      end
      if (!out_ready) last_stall = cyc;
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         model_tab = p_tab;
         err_exp   = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL extra_word: got %h expected no word", out_data);
            end else begin
               check("out_data", out_data, exp_q.pop_front());
               a = acc_q.pop_front();
               if (last_stall <= a) check("latency", 64'(cyc - a), 64'(ST));
               got_q.push_back(out_data);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(p_model(in_data, model_tab));
            acc_q.push_back(cyc);
         end
         err_exp = cfg_we && ((32'(cfg_idx) >= 32'(W)) || (32'(cfg_src) >= 32'(W)));
         if (cfg_we && !err_exp) model_tab[cfg_idx] = int'(cfg_src);
      end
      prev_rst   = rst;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
   end

   // ---------------- stimulus helpers ----------------
   int stall_pct = 0;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 99) >= stall_pct);
      end
   end

   task automatic send(input logic [31:0] w);
      int budget;
      budget   = 0;
      in_data  = w;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         checks++;
         $display("FAIL send_timeout: in_ready low for word %h, required high", w);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      @(negedge clk);
      while (exp_q.size() != 0 && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] idx, input logic [4:0] src);
      cfg_we  = 1'b1;
      cfg_idx = idx;
      cfg_src = src;
      @(posedge clk);
      #1;
      cfg_we  = 1'b0;
   endtask

   task automatic s_send(input logic [23:0] w, input logic [23:0] exp, input string name);
      s_in_data  = w;
      s_in_valid = 1'b1;
      @(negedge clk);
      check({name, "_ready"}, s_in_ready, 1'b1);
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, s_out_valid, 1'b1);
      check({name, "_data"}, s_out_data, exp);
      @(posedge clk);
      #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_idx = 5'd0; cfg_src = 5'd0;
      in_valid = 1'b0; in_data = 32'd0;
      s_rst = 1'b1; s_cfg_we = 1'b0; s_cfg_idx = 5'd0; s_cfg_src = 5'd0;
      s_in_valid = 1'b0; s_in_data = 24'd0; s_out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_data", out_data, 32'd0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_cfg_err", cfg_err, 1'b0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      s_rst = 1'b0;
      @(posedge clk);
      #1;

      // Input bit 0 is the source of output bit 8 under P (P[8] = 0).
      got_q.delete();
      send(32'h8000_0000);
      drain();
      check("p_in_bit0", got_q[0], 32'h0080_0000);

      // Output bit 0 copies input bit 15 (P[0] = 15).
      got_q.delete();
      send(32'h0001_0000);
      drain();
      check("p_in_bit15", got_q[0], 32'h8000_0000);

      // Back-to-back random stream, consumer always ready.
      got_q.delete();
      for (int i = 0; i < 1000; i++) send($urandom());
      drain();
      check("stream_count", 64'(got_q.size()), 64'd1000);

      // Stalling consumer, bursty producer.
      got_q.delete();
      stall_pct = 30;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send($urandom());
      end
      stall_pct = 0;
      drain();
      check("stall_stream_count", 64'(got_q.size()), 64'd200);

      // Identity table.
      for (int k = 0; k < 32; k++) cfg_write(5'(k), 5'(k));
      got_q.delete();
      send(32'hDEAD_BEEF);
      drain();
      check("identity", got_q[0], 32'hDEAD_BEEF);

      // Entry 0 -> 31 written in the acceptance cycle of the first word.
      got_q.delete();
      cfg_we  = 1'b1;
      cfg_idx = 5'd0;
      cfg_src = 5'd31;
      send(32'h0000_0001);
      cfg_we  = 1'b0;
      send(32'h0000_0001);
      drain();
      check("same_cycle_old_entry", got_q[0], 32'h0000_0001);
      check("next_word_new_entry", got_q[1], 32'h8000_0001);

      // Reset with two words held in the pipeline.
      stall_pct = 100;
      @(posedge clk);
      #1;
      got_q.delete();
      send(32'h1234_5678);
      send(32'h9ABC_DEF0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      stall_pct = 0;
      send(32'h0001_0000);
      drain();
      check("flush_count", 64'(got_q.size()), 64'd1);
      check("table_back_to_p", got_q[0], 32'h8000_0000);

      // Narrow instance: identity reset table.
      s_send(24'hABCDEF, 24'hABCDEF, "small_identity");

      // Source out of range.
      s_cfg_we  = 1'b1;
      s_cfg_idx = 5'd5;
      s_cfg_src = 5'd30;
      @(negedge clk);
      check("err_not_early", s_cfg_err, 1'b0);
      @(posedge clk);
      #1;
      s_cfg_we = 1'b0;
      @(negedge clk);
      check("err_pulse", s_cfg_err, 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("err_one_cycle", s_cfg_err, 1'b0);
      @(posedge clk);
      #1;

      // Index out of range.
      s_cfg_we  = 1'b1;
      s_cfg_idx = 5'd25;
      s_cfg_src = 5'd3;
      @(posedge clk);
      #1;
      s_cfg_we = 1'b0;
      @(negedge clk);
      check("err_idx_range", s_cfg_err, 1'b1);
      @(posedge clk);
      #1;
      // DES bit 5 of a 24-bit word is value bit 18; entry 5 must still be 5.
      s_send(24'h04_0000, 24'h04_0000, "small_unchanged");

      // Legal write: entry 0 takes input bit 23 (the LSB).
      s_cfg_we  = 1'b1;
      s_cfg_idx = 5'd0;
      s_cfg_src = 5'd23;
      @(posedge clk);
      #1;
      s_cfg_we = 1'b0;
      @(negedge clk);
      check("legal_no_err", s_cfg_err, 1'b0);
      @(posedge clk);
      #1;
      s_send(24'h00_0001, 24'h80_0001, "small_write");

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
